// File: rtl/uart_rx_deserializer_if.sv
// Receive-side bundle between the serial line, the UART deserializer and its consumer.
// parity_error exists only when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
interface uart_rx_deserializer_if;
    logic       rx;
    logic       uart_rx_valid;
    logic [7:0] receive_data;
    logic       frame_error;
    logic       rx_busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_error;
`endif

    modport master (
        input  rx,
        output uart_rx_valid,
        output receive_data,
        output frame_error,
`ifdef UART_RX_PARITY_EN
        output parity_error,
`endif
        output rx_busy
    );

    modport slave (
        output rx,
        input  uart_rx_valid,
        input  receive_data,
        input  frame_error,
`ifdef UART_RX_PARITY_EN
        input  parity_error,
`endif
        input  rx_busy
    );
endinterface

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: mid-bit sampling, framing-error detection, break hold-off.
// Optional even-parity bit (8E1) when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module uart_rx_deserializer #(
    parameter int CLKS_PER_BIT = 104,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic                     clk,
    input  logic                     reset,
    uart_rx_deserializer_if.master   bus
);

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             sync1_r;
    logic             sync2_r;
    logic             rx_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [2:0]       idx_r;
    logic [2:0]       idx_nxt_s;
    logic [7:0]       shift_r;
    logic [7:0]       shift_nxt_s;
    logic [7:0]       data_r;
    logic [7:0]       data_nxt_s;
    logic             valid_r;
    logic             valid_nxt_s;
    logic             ferr_r;
    logic             ferr_nxt_s;
    logic             busy_r;
    logic             full_s;
`ifdef UART_RX_PARITY_EN
    logic             par_bad_r;
    logic             par_bad_nxt_s;
    logic             perr_r;
    logic             perr_nxt_s;
`endif

    assign rx_s   = sync2_r;
    assign full_s = (cnt_r == FULL_M1);

    // Two-flop synchronizer for the asynchronous serial line; idles high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= bus.rx;
            sync2_r <= sync1_r;
        end
    end

    // State register plus datapath and registered output flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            idx_r     <= 3'd0;
            shift_r   <= 8'h00;
            data_r    <= 8'h00;
            valid_r   <= 1'b0;
            ferr_r    <= 1'b0;
            busy_r    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_r <= 1'b0;
            perr_r    <= 1'b0;
`endif
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            idx_r     <= idx_nxt_s;
            shift_r   <= shift_nxt_s;
            data_r    <= data_nxt_s;
            valid_r   <= valid_nxt_s;
            ferr_r    <= ferr_nxt_s;
            busy_r    <= (state_nxt_s != ST_IDLE);
`ifdef UART_RX_PARITY_EN
            par_bad_r <= par_bad_nxt_s;
            perr_r    <= perr_nxt_s;
`endif
        end
    end

    // Next-state decode; unknown encodings fall back to IDLE.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (!rx_s) state_nxt_s = ST_START;
                else       state_nxt_s = ST_IDLE;
            end
            ST_START: begin
                if (cnt_r == HALF_M1) state_nxt_s = rx_s ? ST_IDLE : ST_DATA;
                else                  state_nxt_s = ST_START;
            end
            ST_DATA: begin
`ifdef UART_RX_PARITY_EN
                if (full_s && (idx_r == 3'd7)) state_nxt_s = ST_PARITY;
`else
                if (full_s && (idx_r == 3'd7)) state_nxt_s = ST_STOP;
`endif
                else                           state_nxt_s = ST_DATA;
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (full_s) state_nxt_s = ST_STOP;
                else        state_nxt_s = ST_PARITY;
            end
`endif
            ST_STOP: begin
                if (full_s) state_nxt_s = rx_s ? ST_IDLE : ST_BREAK;
                else        state_nxt_s = ST_STOP;
            end
            ST_BREAK: begin
                if (rx_s) state_nxt_s = ST_IDLE;
                else      state_nxt_s = ST_BREAK;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Datapath and output-pulse decode for the current state.
    always_comb begin
        cnt_nxt_s     = '0;
        idx_nxt_s     = idx_r;
        shift_nxt_s   = shift_r;
        data_nxt_s    = data_r;
        valid_nxt_s   = 1'b0;
        ferr_nxt_s    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_nxt_s = par_bad_r;
        perr_nxt_s    = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                idx_nxt_s = 3'd0;
`ifdef UART_RX_PARITY_EN
                par_bad_nxt_s = 1'b0;
`endif
            end
            ST_START: begin
                if (cnt_r == HALF_M1) idx_nxt_s = 3'd0;
                else                  cnt_nxt_s = cnt_r + 1'b1;
            end
            ST_DATA: begin
                if (full_s) begin
                    shift_nxt_s[idx_r] = rx_s;
                    idx_nxt_s          = idx_r + 3'd1;
                end else begin
                    cnt_nxt_s = cnt_r + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (full_s) par_bad_nxt_s = rx_s ^ (^shift_r);
                else        cnt_nxt_s     = cnt_r + 1'b1;
            end
`endif
            ST_STOP: begin
                if (full_s) begin
                    if (!rx_s) begin
                        ferr_nxt_s = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad_r) begin
                        perr_nxt_s = 1'b1;
`endif
                    end else begin
                        valid_nxt_s = 1'b1;
                        data_nxt_s  = shift_r;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + 1'b1;
                end
            end
            ST_BREAK: begin
                cnt_nxt_s = '0;
            end
            default: begin
                idx_nxt_s = 3'd0;
            end
        endcase
    end

    assign bus.uart_rx_valid = valid_r;
    assign bus.receive_data  = data_r;
    assign bus.frame_error   = ferr_r;
    assign bus.rx_busy       = busy_r;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_error  = perr_r;
`endif

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- Upstream stage of the UART-to-memory controller. It deserializes 8N1 async serial frames from the host into bytes.
- Delivers each byte as receive_data with a one-cycle uart_rx_valid pulse. The controller's COMMAND/ADDR/SIZE/RX_*/SP_ADDR_* states consume this pulse.
- Also flags framing errors and exposes a busy indicator for the board LEDs.

Parameters:
- CLKS_PER_BIT, 104, system clocks per bit period (12 MHz / 115200 baud). Legal range 4..65535.
- CNT_W, $clog2(CLKS_PER_BIT), width of the bit-period counter (derived; not overridden).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- rx  input  1  raw serial line, idle high, asynchronous to clk
- uart_rx_valid  output  1  one-cycle pulse; receive_data holds a new good byte
- receive_data  output  8  last good byte received, LSB first on the wire
- frame_error  output  1  one-cycle pulse; stop bit sampled low
- rx_busy  output  1  high while a frame is in progress (any state other than IDLE)

Behaviour:
- Reset (async, active-high):
  - state=IDLE; both synchronizer flops=1; bit counter=0; bit index=0; shift register=0.
  - receive_data=8'h00; uart_rx_valid=0; frame_error=0; rx_busy=0.
  - Reset mid-frame abandons the frame: no valid or error pulse, and receive_data keeps 0.
- rx passes through a 2-flop synchronizer. All decisions use the second flop (rx_s).
- States:
  - IDLE → START when rx_s==0. Clear the counter.
  - START: count to (CLKS_PER_BIT/2)-1 (integer floor), then sample rx_s.
    - rx_s==0 → DATA, counter=0, index=0.
    - rx_s==1 → IDLE (glitch rejected, no output).
  - DATA: at counter==CLKS_PER_BIT-1, sample rx_s into shift bit [index] and reset the counter.
    - After index 7, go to STOP. Otherwise index++.
  - STOP: at counter==CLKS_PER_BIT-1, sample rx_s.
    - rx_s==1 → receive_data<=shift register, uart_rx_valid=1 for exactly one cycle, → IDLE.
    - rx_s==0 → frame_error=1 for exactly one cycle, receive_data unchanged, → BREAK_WAIT.
  - BREAK_WAIT: stay until rx_s==1, then → IDLE. A held-low break line must not retrigger frames.
  - Illegal or unused state encodings → IDLE on the next clock.
- Latency:
  - Samples fall at mid-bit. The stop sample is at about 9.5 bit periods after the falling edge, plus 2 synchronizer cycles.
  - uart_rx_valid asserts the cycle after the stop sample.
- Back-to-back frames: IDLE is reached mid-stop-bit. A start edge arriving immediately after the stop bit must be captured with no lost byte.
- uart_rx_valid and frame_error are never high in the same cycle. Neither is high twice for one frame.
- receive_data is stable from the valid pulse until the next valid pulse. The controller's stall states depend on this.
- Counter arithmetic is unsigned CNT_W bits and never wraps, because the compare fires before overflow.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- When defined:
  - Adds state PARITY between DATA and STOP, sampled like a data bit. Even parity.
  - Adds output parity_error (1 bit, reset 0).
  - Parity mismatch with a good stop bit → parity_error pulses one cycle. No uart_rx_valid, and receive_data is unchanged.
  - Mismatch with a bad stop bit → frame_error only.
- When undefined: no PARITY state and no parity_error port; the frame is 8N1 exactly as above.

Test Plan:
- CLKS_PER_BIT=16, send 8'hA5 with 2 idle bits → exactly one uart_rx_valid pulse, receive_data==8'hA5, frame_error never high, rx_busy falls at valid.
- Send 8'h00 then 8'hFF with zero idle between stop and next start → two valid pulses, data 8'h00 then 8'hFF, in order.
- Drive rx low for 5 clocks then high (glitch) → no valid, no frame_error, state back to IDLE. Then send 8'h3C → received correctly.
- Send 8'h81 with stop bit 0, then hold rx low 40 clocks, release, then send 8'h42 → one frame_error pulse, no valid for 8'h81, receive_data stays at prior value, next valid carries 8'h42.
- Assert reset during data bit 4 of 8'h5A, release, then send 8'hC3 → outputs at reset values during and after reset, no pulse for the aborted frame, valid with 8'hC3.
- With UART_RX_PARITY_EN: send 8'h07 with parity 1 (correct) → valid, data 8'h07. Send 8'h07 with parity 0 → parity_error pulse, no valid.
